// File: rtl/pool_window_gen.sv
// Generates non-overlapping 2x2 pooling windows from a raster-order pixel stream.
// Even rows are buffered; each odd-row, odd-column pixel completes one window.
module pool_window_gen #(
  parameter int unsigned DATA_W = 22,
  parameter int unsigned IMG_W  = 24,
  parameter int unsigned IMG_H  = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pixelIn,
  input  logic              pixelValid,
  output logic [DATA_W-1:0] window1,
  output logic [DATA_W-1:0] window2,
  output logic [DATA_W-1:0] window3,
  output logic [DATA_W-1:0] window4,
  output logic              windowValid,
  output logic              frameDone
);

  localparam int unsigned ColW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);

  logic [ColW-1:0]   col_q;
  logic [RowW-1:0]   row_q;
  logic [DATA_W-1:0] linebuf_q [IMG_W];
  logic [DATA_W-1:0] prev_pix_q;
  logic [DATA_W-1:0] win1_q, win2_q, win3_q, win4_q;
  logic              win_valid_q, frame_done_q;

  logic            col_last, row_last;
  logic [ColW-1:0] col_even;

  assign col_last = (col_q == ColLast);
  assign row_last = (row_q == RowLast);
  // Odd column minus one is the same address with bit 0 cleared.
  assign col_even = col_q & ~ColW'(1);

  // Line buffer holds the most recent even row; not reset.
  always_ff @(posedge clk) begin
    if (!reset && pixelValid && !row_q[0]) begin
      linebuf_q[col_q] <= pixelIn;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      prev_pix_q   <= '0;
      win1_q       <= '0;
      win2_q       <= '0;
      win3_q       <= '0;
      win4_q       <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (pixelValid) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + RowW'(1);
        end else begin
          col_q <= col_q + ColW'(1);
        end
        if (row_q[0]) begin
          if (!col_q[0]) begin
            prev_pix_q <= pixelIn;
          end else begin
            win1_q       <= linebuf_q[col_even];
            win2_q       <= linebuf_q[col_q];
            win3_q       <= prev_pix_q;
            win4_q       <= pixelIn;
            win_valid_q  <= 1'b1;
            frame_done_q <= col_last && row_last;
          end
        end
      end
    end
  end

  assign window1     = win1_q;
  assign window2     = win2_q;
  assign window3     = win3_q;
  assign window4     = win4_q;
  assign windowValid = win_valid_q;
  assign frameDone   = frame_done_q;

endmodule

// File: tb/tb_pool_window_gen.sv
// Directed bench for pool_window_gen: a 4x4 instance for the directed scenarios
// and a default 24x24 instance checked against a whole-frame reference.
module tb_pool_window_gen;

  localparam int unsigned DW = 22;

  logic          clk = 1'b0;
  logic          s_reset, s_valid;
  logic [DW-1:0] s_pix;
  logic [DW-1:0] s_w1, s_w2, s_w3, s_w4;
  logic          s_wv, s_fd;

  logic          b_reset, b_valid;
  logic [DW-1:0] b_pix;
  logic [DW-1:0] b_w1, b_w2, b_w3, b_w4;
  logic          b_wv, b_fd;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] last_w [4];
  logic [DW-1:0] frame [24][24];

  always #5 clk = ~clk;

  pool_window_gen #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) u_small (
    .clk        (clk),
    .reset      (s_reset),
    .pixelIn    (s_pix),
    .pixelValid (s_valid),
    .window1    (s_w1),
    .window2    (s_w2),
    .window3    (s_w3),
    .window4    (s_w4),
    .windowValid(s_wv),
    .frameDone  (s_fd)
  );

  pool_window_gen u_big (
    .clk        (clk),
    .reset      (b_reset),
    .pixelIn    (b_pix),
    .pixelValid (b_valid),
    .window1    (b_w1),
    .window2    (b_w2),
    .window3    (b_w3),
    .window4    (b_w4),
    .windowValid(b_wv),
    .frameDone  (b_fd)
  );

  // Drive one cycle on the small instance, return just after the sampling edge.
  task automatic s_step(input logic [DW-1:0] p, input logic v, input logic r);
    @(negedge clk);
    s_pix   = p;
    s_valid = v;
    s_reset = r;
    @(posedge clk);
    #1;
  endtask

  task automatic b_step(input logic [DW-1:0] p, input logic v, input logic r);
    @(negedge clk);
    b_pix   = p;
    b_valid = v;
    b_reset = r;
    @(posedge clk);
    #1;
  endtask

  // Stream one 4x4 frame whose pixel k has value base+k (with optional idle cycles
  // between pixels) and check every strobe, window and hold.
  task automatic run_frame(input string name, input int base, input int gap, output int nwin,
                           output int nfd);
    logic [DW-1:0] e [4];
    logic          qual;
    nwin = 0;
    nfd  = 0;
    for (int k = 0; k < 16; k++) begin
      s_step(DW'(base + k), 1'b1, 1'b0);
      qual = (k % 2 == 1) && ((k / 4) % 2 == 1);
      if (qual) begin
        e[0] = DW'(base + k - 5);
        e[1] = DW'(base + k - 4);
        e[2] = DW'(base + k - 1);
        e[3] = DW'(base + k);
      end
      n_tests++;
      if (s_wv !== qual) begin
        $display("FAIL %s wv pix %0d: got %b want %b", name, k, s_wv, qual);
        n_fail++;
      end
      n_tests++;
      if (s_fd !== (k == 15)) begin
        $display("FAIL %s fd pix %0d: got %b want %b", name, k, s_fd, k == 15);
        n_fail++;
      end
      if (s_wv) nwin++;
      if (s_fd) nfd++;
      if (qual) begin
        n_tests++;
        if ({s_w1, s_w2, s_w3, s_w4} !== {e[0], e[1], e[2], e[3]}) begin
          $display("FAIL %s win pix %0d: got %h %h %h %h want %h %h %h %h", name, k,
                   s_w1, s_w2, s_w3, s_w4, e[0], e[1], e[2], e[3]);
          n_fail++;
        end
        last_w = e;
      end
      for (int g = 0; g < gap; g++) begin
        s_step(DW'(32'h3A5A5), 1'b0, 1'b0);
        n_tests++;
        if (s_wv !== 1'b0 || s_fd !== 1'b0 ||
            {s_w1, s_w2, s_w3, s_w4} !== {last_w[0], last_w[1], last_w[2], last_w[3]}) begin
          $display("FAIL %s hold pix %0d: got %b %b %h %h %h %h", name, k, s_wv, s_fd,
                   s_w1, s_w2, s_w3, s_w4);
          n_fail++;
        end
      end
    end
  endtask

  task automatic test_reset();
    s_step('1, 1'b1, 1'b1);
    b_step('1, 1'b1, 1'b1);
    n_tests++;
    if (s_wv !== 1'b0 || s_fd !== 1'b0) begin
      $display("FAIL reset strobes: got wv=%b fd=%b want 0 0", s_wv, s_fd);
      n_fail++;
    end
    n_tests++;
    if ({s_w1, s_w2, s_w3, s_w4} !== '0) begin
      $display("FAIL reset windows: got %h %h %h %h want 0", s_w1, s_w2, s_w3, s_w4);
      n_fail++;
    end
    n_tests++;
    if (b_wv !== 1'b0 || b_fd !== 1'b0 || {b_w1, b_w2, b_w3, b_w4} !== '0) begin
      $display("FAIL reset big: got wv=%b fd=%b w1=%h", b_wv, b_fd, b_w1);
      n_fail++;
    end
    s_step('0, 1'b0, 1'b0);
    b_step('0, 1'b0, 1'b0);
    last_w = '{default: '0};
  endtask

  task automatic test_continuous();
    int nwin, nfd;
    run_frame("cont", 0, 0, nwin, nfd);
    n_tests++;
    if (nwin != 4 || nfd != 1) begin
      $display("FAIL cont count: got %0d win %0d fd want 4 1", nwin, nfd);
      n_fail++;
    end
  endtask

  task automatic test_gaps();
    int nwin, nfd;
    run_frame("gaps", 0, 2, nwin, nfd);
    n_tests++;
    if (nwin != 4 || nfd != 1) begin
      $display("FAIL gaps count: got %0d win %0d fd want 4 1", nwin, nfd);
      n_fail++;
    end
  endtask

  task automatic test_extremes();
    logic [DW-1:0] p;
    for (int k = 0; k < 16; k++) begin
      case (k)
        0:       p = 22'h200000;
        1:       p = 22'h3FFFFF;
        4:       p = 22'h000001;
        5:       p = 22'h1FFFFF;
        default: p = DW'(k);
      endcase
      s_step(p, 1'b1, 1'b0);
      if (k == 5) begin
        n_tests++;
        if (s_wv !== 1'b1 ||
            {s_w1, s_w2, s_w3, s_w4} !== {22'h200000, 22'h3FFFFF, 22'h000001, 22'h1FFFFF}) begin
          $display("FAIL extremes win: got wv=%b %h %h %h %h want 1 200000 3fffff 000001 1fffff",
                   s_wv, s_w1, s_w2, s_w3, s_w4);
          n_fail++;
        end
      end
      if (k == 15) begin
        n_tests++;
        if (s_fd !== 1'b1 || {s_w1, s_w2, s_w3, s_w4} !== {22'd10, 22'd11, 22'd14, 22'd15}) begin
          $display("FAIL extremes last: got fd=%b %h %h %h %h want 1 a b e f",
                   s_fd, s_w1, s_w2, s_w3, s_w4);
          n_fail++;
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int nwin, nfd;
    for (int k = 0; k < 10; k++) s_step(DW'(50 + k), 1'b1, 1'b0);
    s_step(DW'(77), 1'b1, 1'b1);
    n_tests++;
    if (s_wv !== 1'b0 || s_fd !== 1'b0 || {s_w1, s_w2, s_w3, s_w4} !== '0) begin
      $display("FAIL midreset state: got wv=%b fd=%b %h %h %h %h want all 0", s_wv, s_fd,
               s_w1, s_w2, s_w3, s_w4);
      n_fail++;
    end
    last_w = '{default: '0};
    run_frame("midreset", 200, 0, nwin, nfd);
    n_tests++;
    if (nwin != 4 || nfd != 1) begin
      $display("FAIL midreset count: got %0d win %0d fd want 4 1", nwin, nfd);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    int nwin_a, nfd_a, nwin_b, nfd_b;
    run_frame("b2b_f1", 0, 0, nwin_a, nfd_a);
    run_frame("b2b_f2", 100, 0, nwin_b, nfd_b);
    n_tests++;
    if (nwin_a + nwin_b != 8 || nfd_a + nfd_b != 2) begin
      $display("FAIL b2b count: got %0d win %0d fd want 8 2", nwin_a + nwin_b, nfd_a + nfd_b);
      n_fail++;
    end
  endtask

  task automatic test_random_24();
    int nwin = 0;
    int nfd  = 0;
    int r = 0;
    int c = 0;
    logic qual;
    while (r < 24) begin
      if ($urandom_range(3) == 0) begin
        b_step(DW'($urandom), 1'b0, 1'b0);
        n_tests++;
        if (b_wv !== 1'b0 || b_fd !== 1'b0) begin
          $display("FAIL rand24 idle (%0d,%0d): got wv=%b fd=%b", c, r, b_wv, b_fd);
          n_fail++;
        end
        continue;
      end
      frame[r][c] = DW'($urandom);
      b_step(frame[r][c], 1'b1, 1'b0);
      qual = r[0] && c[0];
      n_tests++;
      if (b_wv !== qual || b_fd !== (r == 23 && c == 23)) begin
        $display("FAIL rand24 strobe (%0d,%0d): got wv=%b fd=%b want %b %b", c, r, b_wv, b_fd,
                 qual, r == 23 && c == 23);
        n_fail++;
      end
      if (b_wv) nwin++;
      if (b_fd) nfd++;
      if (qual) begin
        n_tests++;
        if ({b_w1, b_w2, b_w3, b_w4} !==
            {frame[r-1][c-1], frame[r-1][c], frame[r][c-1], frame[r][c]}) begin
          $display("FAIL rand24 win (%0d,%0d): got %h %h %h %h want %h %h %h %h", c, r,
                   b_w1, b_w2, b_w3, b_w4,
                   frame[r-1][c-1], frame[r-1][c], frame[r][c-1], frame[r][c]);
          n_fail++;
        end
      end
      c++;
      if (c == 24) begin
        c = 0;
        r++;
      end
    end
    n_tests++;
    if (nwin != 144 || nfd != 1) begin
      $display("FAIL rand24 count: got %0d win %0d fd want 144 1", nwin, nfd);
      n_fail++;
    end
  endtask

  initial begin
    s_reset = 1'b1;
    s_valid = 1'b0;
    s_pix   = '0;
    b_reset = 1'b1;
    b_valid = 1'b0;
    b_pix   = '0;
    test_reset();
    test_continuous();
    test_gaps();
    test_extremes();
    test_reset_midframe();
    test_back_to_back();
    test_random_24();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pool_window_gen.md
POOL_WINDOW_GEN -- requirements
Module: pool_window_gen

Interface
REQ-001 The module SHALL have parameter DATA_W, default 22, the pixel word width in bits, two's complement.
REQ-002 The module SHALL have parameter IMG_W, default 24, the feature-map width in pixels; it must be even and at least 2.
REQ-003 The module SHALL have parameter IMG_H, default 24, the feature-map height in pixels; it must be even and at least 2.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port pixelIn, input, DATA_W bits: the feature-map pixel, raster order, row-major.
REQ-007 The module SHALL have port pixelValid, input, 1 bit: pixelIn is accepted on every rising clk edge where this is high.
REQ-008 The module SHALL have ports window1, window2, window3 and window4, each an output of DATA_W bits: the 2x2 window as top-left, top-right, bottom-left and bottom-right, in that order.
REQ-009 The module SHALL have port windowValid, output, 1 bit: a one-cycle strobe marking a new window; it drives the pooling stage's enable.
REQ-010 The module SHALL have port frameDone, output, 1 bit: a one-cycle strobe coincident with the last window of a frame.

Function
REQ-011 The module SHALL track the position of each accepted pixel with a column counter (0..IMG_W-1) and a row counter (0..IMG_H-1).
REQ-012 On an accepted pixel, col SHALL increment; at IMG_W-1 col SHALL wrap to 0 and row SHALL increment.
REQ-013 At (IMG_W-1, IMG_H-1), both counters SHALL wrap to 0; the next accepted pixel is (0,0) of a new frame with no idle cycle required.
REQ-014 Counters SHALL NOT change in cycles where pixelValid is low; gaps of any length are legal.
REQ-015 Even rows (row[0]=0) SHALL be written into a line buffer of IMG_W entries of DATA_W bits, at address col.
REQ-016 On an odd row, a pixel at even col SHALL be held in a register, prevPix.
REQ-017 On an odd row, a pixel at odd col SHALL register window1=linebuf[col-1], window2=linebuf[col], window3=prevPix and window4=pixelIn.
REQ-018 In that same case windowValid SHALL be 1 in the following cycle; latency is 1 clk from the accepting edge.
REQ-019 windowValid SHALL be 0 in every other cycle and SHALL never be high for two consecutive cycles unless two qualifying pixels are accepted on consecutive edges.
REQ-020 frameDone SHALL be 1 in the same cycle as the windowValid for pixel (IMG_W-1, IMG_H-1), and 0 otherwise.
REQ-021 window1..4 SHALL hold their last values while windowValid is 0; consumers sample only when windowValid=1.
REQ-022 Data SHALL pass bit-exact with no sign extension, saturation or arithmetic; negative values, including the most negative value (1 followed by DATA_W-1 zeros), SHALL be preserved.
REQ-023 Each frame SHALL produce exactly (IMG_W/2)*(IMG_H/2) windows.
REQ-024 Line-buffer reads for row r+1 SHALL return row r data; a write to address col and a read of col/col-1 never coincide in the same row parity.
REQ-025 The module SHALL have no backpressure; the downstream stage must accept a window every cycle windowValid=1.

Reset
REQ-026 While reset=1, col, row, windowValid and frameDone SHALL be 0, and window1..4 and prevPix SHALL be 0.
REQ-027 Line-buffer contents are not reset; their values are don't-care until rewritten by the next even row.
REQ-028 Reset SHALL take priority over pixelValid in the same cycle; a pixel presented with reset=1 is discarded.
REQ-029 A reset asserted mid-frame SHALL abort the frame, and the first pixel accepted after reset deasserts is (0,0).

Verification
REQ-030 IMG_W=4, IMG_H=4, pixels 0..15 streamed continuously -> windows (0,1,4,5), (2,3,6,7), (8,9,12,13) and (10,11,14,15), each 1 cycle after pixels 5, 7, 13 and 15 respectively; frameDone with the last window only.
REQ-031 Same frame with pixelValid toggled 1,0,0,1,... -> identical window values and count; each windowValid is 1 cycle after its qualifying pixel; outputs hold between strobes.
REQ-032 DATA_W=22 with pixels 22'h200000, 22'h3FFFFF, 22'h000001 and 22'h1FFFFF forming one window -> outputs equal to the inputs bit-exact, in the correct positions.
REQ-033 Reset asserted after pixel 9 of a 4x4 frame, then pixels 0..15 streamed -> no window emitted from pre-reset data, and exactly 4 correct windows produced.
REQ-034 Two 4x4 frames back-to-back without a gap -> 8 windows, 2 frameDone pulses, and the second frame's windows use only second-frame data.
REQ-035 Default parameters (24x24), random data -> 144 windows, each matching a reference model, with frameDone once per frame.
